ip_tile: RTL and testbench

//  Single-precision (IEEE-754 binary32) floating-point add/subtract tile behind a CSR/data-register

---
 rtl/ip_tile.sv | 214 +++++++++++++++++++++
 tb/tb_ip_tile.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_tile.sv
// Binary32 add/subtract tile behind a CSR/data-register interface.
// Five-state pipeline: IDLE capture, ALIGN, ADD, NORM, ROUND with RNE and IEEE specials.
module ip_tile #(
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int REG_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [CSR_IN_WIDTH-1:0]  csr_in,
  output logic                     csr_in_re,
  input  logic [REG_WIDTH-1:0]     data_reg_a,
  input  logic [REG_WIDTH-1:0]     data_reg_b,
  output logic [CSR_OUT_WIDTH-1:0] csr_out,
  output logic                     csr_out_we,
  output logic [REG_WIDTH-1:0]     data_reg_c
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state, state_nx;

  logic        start;
  logic        unused_csr;
  logic [31:0] op_a, op_b;

  assign start      = csr_in[15];
  assign unused_csr = ^{csr_in[14:5], csr_in[3:0]};

  // pipeline registers
  logic        sx_r, sy_r, sgn_r;
  logic [9:0]  e_r;
  logic [26:0] mx_r, my_r, nm_r;
  logic [27:0] sum_r;
  logic        spec_r, spec_inv_r;
  logic [31:0] spec_val_r;

  // ALIGN stage combinational
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic        spec_hit, spec_inv;
  logic [31:0] spec_val, x, y;
  logic [7:0]  x_exp, y_exp, e_diff;
  logic [26:0] y_ext, y_al;

  always_comb begin
    a_nan    = (&op_a[30:23]) & (|op_a[22:0]);
    b_nan    = (&op_b[30:23]) & (|op_b[22:0]);
    a_inf    = (&op_a[30:23]) & ~(|op_a[22:0]);
    b_inf    = (&op_b[30:23]) & ~(|op_b[22:0]);
    spec_hit = 1'b1;
    spec_val = QNAN;
    spec_inv = 1'b0;
    if (a_nan | b_nan)
      spec_inv = (a_nan & ~op_a[22]) | (b_nan & ~op_b[22]);
    else if (a_inf & b_inf & (op_a[31] ^ op_b[31]))
      spec_inv = 1'b1;
    else if (a_inf)
      spec_val = op_a;
    else if (b_inf)
      spec_val = op_b;
    else
      spec_hit = 1'b0;
    swap   = op_b[30:0] > op_a[30:0];
    x      = swap ? op_b : op_a;
    y      = swap ? op_a : op_b;
    x_exp  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    y_exp  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    y_ext  = {(|y[30:23]), y[22:0], 3'b000};
    e_diff = x_exp - y_exp;
    if (e_diff >= 8'd26)
      y_al = {26'd0, |y_ext};
    else
      y_al = (y_ext >> e_diff) | {26'd0, |(y_ext & ((27'd1 << e_diff) - 27'd1))};
  end

  // NORM stage: left shift is capped so the exponent never drops below 1 (subnormal output)
  logic [4:0]  lz;
  logic [9:0]  lim, sh, ne;
  logic [26:0] nm;

  always_comb begin
    lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (sum_r[i]) lz = 5'(26 - i);
    lim = e_r - 10'd1;
    sh  = '0;
    if (sum_r[27]) begin
      nm = {sum_r[27:2], |sum_r[1:0]};
      ne = e_r + 10'd1;
    end else begin
      sh = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
      nm = sum_r[26:0] << sh;
      ne = e_r - sh;
    end
  end

  // ROUND stage
  logic        rnd_up, f_inv, f_ovf, f_unf, f_inx;
  logic [24:0] mr;
  logic [9:0]  re;
  logic [22:0] rf;
  logic [31:0] res;
  logic [8:0]  stat;

  always_comb begin
    rnd_up = nm_r[2] & ((|nm_r[1:0]) | nm_r[3]);
    mr     = {1'b0, nm_r[26:3]} + 25'(rnd_up);
    if (mr[24]) begin
      re = e_r + 10'd1;
      rf = '0;
    end else begin
      re = mr[23] ? e_r : 10'd0;
      rf = mr[22:0];
    end
    f_inv = 1'b0;
    f_ovf = 1'b0;
    f_unf = 1'b0;
    f_inx = 1'b0;
    if (spec_r) begin
      res   = spec_val_r;
      f_inv = spec_inv_r;
    end else if (re >= 10'd255) begin
      res   = {sgn_r, 8'hFF, 23'd0};
      f_ovf = 1'b1;
      f_inx = 1'b1;
    end else begin
      res   = {sgn_r, re[7:0], rf};
      f_inx = |nm_r[2:0];
      f_unf = ~nm_r[26] & f_inx;
    end
    stat = {res[31],
            (&res[30:23]) & (|res[22:0]),
            (&res[30:23]) & ~(|res[22:0]),
            ~(|res[30:0]),
            f_inx, f_unf, f_ovf, f_inv, 1'b1};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      csr_in_re  <= 1'b0;
      csr_out_we <= 1'b0;
      csr_out    <= '0;
      data_reg_c <= '0;
      op_a       <= '0;
      op_b       <= '0;
      sx_r       <= 1'b0;
      sy_r       <= 1'b0;
      sgn_r      <= 1'b0;
      e_r        <= '0;
      mx_r       <= '0;
      my_r       <= '0;
      nm_r       <= '0;
      sum_r      <= '0;
      spec_r     <= 1'b0;
      spec_inv_r <= 1'b0;
      spec_val_r <= '0;
    end else begin
      csr_in_re  <= 1'b0;
      csr_out_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_a      <= data_reg_a[31:0];
          op_b      <= {data_reg_b[31] ^ csr_in[4], data_reg_b[30:0]};
          csr_in_re <= 1'b1;
        end
        ALIGN: begin
          sx_r       <= x[31];
          sy_r       <= y[31];
          e_r        <= {2'b00, x_exp};
          mx_r       <= {(|x[30:23]), x[22:0], 3'b000};
          my_r       <= y_al;
          spec_r     <= spec_hit;
          spec_inv_r <= spec_inv;
          spec_val_r <= spec_val;
        end
        ADD: begin
          sum_r <= (sx_r == sy_r) ? {1'b0, mx_r} + {1'b0, my_r}
                                  : {1'b0, mx_r} - {1'b0, my_r};
          // exact cancellation of opposite signs yields +0
          sgn_r <= ((sx_r != sy_r) && (mx_r == my_r)) ? 1'b0 : sx_r;
        end
        NORM: begin
          nm_r <= nm;
          e_r  <= ne;
        end
        ROUND: begin
          data_reg_c <= REG_WIDTH'(res);
          csr_out    <= CSR_OUT_WIDTH'(stat);
          csr_out_we <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tile.sv
// Scoreboard bench for ip_tile: directed IEEE cases plus randomized operands checked
// against a reference built on double-precision arithmetic with explicit RNE narrowing.
module tb_ip_tile;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] csr_in;
  logic        csr_in_re;
  logic [31:0] data_reg_a, data_reg_b, data_reg_c;
  logic [15:0] csr_out;
  logic        csr_out_we;

  ip_tile #(.CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .REG_WIDTH(32)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .csr_in     (csr_in),
    .csr_in_re  (csr_in_re),
    .data_reg_a (data_reg_a),
    .data_reg_b (data_reg_b),
    .csr_out    (csr_out),
    .csr_out_we (csr_out_we),
    .data_reg_c (data_reg_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] c;
    logic [15:0] st;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_c   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // binary32 -> binary64 bit pattern (exact)
  function automatic logic [63:0] to_dbl(input logic [31:0] f);
    logic [23:0] m;
    int          e;
    if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'd0};
    if (f[30:0] == 31'd0)  return {f[31], 63'd0};
    if (f[30:23] == 8'd0) begin
      m = {1'b0, f[22:0]};
      e = -126;
      while (!m[23]) begin
        m = m << 1;
        e--;
      end
    end else begin
      m = {1'b1, f[22:0]};
      e = int'(f[30:23]) - 127;
    end
    return {f[31], 11'(e + 1023), m[22:0], 29'd0};
  endfunction

  // double -> binary32 with RNE; returns {overflow, inexact, tiny, result}
  function automatic logic [34:0] from_dbl(input real r);
    logic [63:0] d, m, q, rem, half;
    int          fe, sh;
    logic        s;
    d = $realtobits(r);
    s = d[63];
    if (d[62:52] == 11'h7FF) return {3'b000, s, 8'hFF, 23'd0};
    if (d[62:0] == 63'd0)    return {3'b000, s, 31'd0};
    fe = int'(d[62:52]) - 1023 + 127;
    m  = {11'd0, 1'b1, d[51:0]};
    sh = 29 + ((fe < 1) ? (1 - fe) : 0);
    if (sh > 62) sh = 62;
    q    = m >> sh;
    rem  = m & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (fe < 1) return {1'b0, rem != 64'd0, 1'b1, s, q[30:0]};
    if (q[24]) begin
      q = q >> 1;
      fe++;
    end
    if (fe >= 255) return {2'b11, 1'b0, s, 8'hFF, 23'd0};
    return {1'b0, rem != 64'd0, 1'b0, s, 8'(fe), q[22:0]};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] bb, r;
    logic        an, bn, ai, bi, inv, ovf, inx, tiny;
    logic [34:0] cv;
    exp_t        e;
    bb  = {b[31] ^ op, b[30:0]};
    an  = (&a[30:23]) && (|a[22:0]);
    bn  = (&bb[30:23]) && (|bb[22:0]);
    ai  = (&a[30:23]) && !(|a[22:0]);
    bi  = (&bb[30:23]) && !(|bb[22:0]);
    inv = 1'b0; ovf = 1'b0; inx = 1'b0; tiny = 1'b0;
    if (an || bn) begin
      r   = 32'h7FC0_0000;
      inv = (an && !a[22]) || (bn && !bb[22]);
    end else if (ai && bi && (a[31] != bb[31])) begin
      r   = 32'h7FC0_0000;
      inv = 1'b1;
    end else begin
      cv   = from_dbl($bitstoreal(to_dbl(a)) + $bitstoreal(to_dbl(bb)));
      r    = cv[31:0];
      tiny = cv[32];
      inx  = cv[33];
      ovf  = cv[34];
    end
    e.c  = r;
    e.st = {7'd0, r[31], (&r[30:23]) && (|r[22:0]), (&r[30:23]) && !(|r[22:0]),
            r[30:0] == 31'd0, inx, tiny && inx, ovf, inv, 1'b1};
    return e;
  endfunction

  always @(negedge clk) begin
    if (csr_out_we) begin
      if (sb.size() == 0) check("spurious_we", 64'(csr_out_we), 64'd0);
      else begin
        mon_e = sb.pop_front();
        check("result_c", 64'(data_reg_c), 64'(mon_e.c));
        check("status",   64'(csr_out),    64'(mon_e.st));
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op, input exp_t want);
    logic seen;
    int   lat;
    @(negedge clk);
    data_reg_a = a;
    data_reg_b = b;
    csr_in     = {11'd0, op, 4'd0} | 16'h8000;
    sb.push_back(want);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = csr_in_re;
    end
    check("ack_seen", 64'(seen), 64'd1);
    csr_in = '0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (csr_out_we) break;
    end
    check("latency", 64'(lat), 64'd4);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    last_c = want.c;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        op, seen;
    int          ea, eb, d, sel, n_re;
    csr_in     = '0;
    data_reg_a = '0;
    data_reg_b = '0;
    arst_n     = 1'b1;
    #1 arst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_c",   64'(data_reg_c), 64'd0);
    check("rst_csr", 64'(csr_out),    64'd0);
    check("rst_re",  64'(csr_in_re),  64'd0);
    check("rst_we",  64'(csr_out_we), 64'd0);
    arst_n = 1'b1;

    run_op(32'h4120_0000, 32'h40A0_0000, 1'b0, {32'h4170_0000, 16'h0001});
    run_op(32'h4160_0000, 32'h40A0_0000, 1'b1, {32'h4110_0000, 16'h0001});
    run_op(32'hC120_0000, 32'hC0A0_0000, 1'b0, {32'hC170_0000, 16'h0101});
    run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, {32'h7FC0_0000, 16'h0083});
    run_op(32'h7F80_0000, 32'h4120_0000, 1'b0, {32'h7F80_0000, 16'h0041});
    run_op(32'h4120_400A, 32'h4120_400A, 1'b1, {32'h0000_0000, 16'h0021});
    run_op(32'h0000_0000, 32'h4120_0000, 1'b1, {32'hC120_0000, 16'h0101});
    run_op(32'h0040_0000, 32'h0047_1000, 1'b0, {32'h0087_1000, 16'h0001});
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, {32'h7F80_0000, 16'h0055});
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, {32'h8000_0000, 16'h0121});
    run_op(32'h7F80_0001, 32'h3F80_0000, 1'b0, {32'h7FC0_0000, 16'h0083});
    run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, {32'h3F80_0000, 16'h0011});
    run_op(32'h3F80_0000, 32'h3380_0001, 1'b0, {32'h3F80_0001, 16'h0011});
    run_op(32'h3F80_0000, 32'h3300_0000, 1'b1, {32'h3F80_0000, 16'h0011});

    // command without start bit: nothing happens, result held
    @(negedge clk);
    csr_in     = 16'h0010;
    data_reg_a = 32'h4000_0000;
    data_reg_b = 32'h4040_0000;
    n_re = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (csr_in_re) n_re++;
    end
    check("noop_re",     64'(n_re),       64'd0);
    check("noop_hold_c", 64'(data_reg_c), 64'(last_c));
    csr_in = '0;

    for (int i = 0; i < 48; i++) begin
      sel = int'($urandom_range(0, 7));
      ea  = (sel < 2) ? int'($urandom_range(0, 3)) :
            (sel == 2) ? int'($urandom_range(250, 254)) : int'($urandom_range(1, 253));
      d   = int'($urandom_range(0, 28));
      eb  = ($urandom_range(0, 1) != 0) ? ea + d : ea - d;
      if (eb > 254) eb = 254;
      if (eb < 0)   eb = 0;
      ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (sel == 7) rb = ra;
      op = 1'($urandom_range(0, 1));
      run_op(ra, rb, op, model(ra, rb, op));
    end

    // reset while busy: outputs clear and the aborted op never writes back
    @(negedge clk);
    data_reg_a = 32'h4120_0000;
    data_reg_b = 32'h3F80_0000;
    csr_in     = 16'h8000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = csr_in_re;
    end
    check("abort_ack", 64'(seen), 64'd1);
    csr_in = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("abort_c",   64'(data_reg_c), 64'd0);
    check("abort_csr", 64'(csr_out),    64'd0);
    check("abort_we",  64'(csr_out_we), 64'd0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_abort_c", 64'(data_reg_c), 64'd0);

    run_op(32'h4120_0000, 32'h40A0_0000, 1'b0, {32'h4170_0000, 16'h0001});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
